// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream loopback receive path:
// width defaults, the ceil-log2 helper and the receive-state encoding.
package axis_pkg;

    localparam int C_DEFAULT_TDATA_WIDTH = 32;

    typedef enum logic [1:0] {
        RX_IDLE = 2'b00,
        RX_PKT  = 2'b01,
        RX_OVER = 2'b10
    } rx_state_t;

    // Returns ceil(log2(value)); 0 for value <= 1.
    function automatic int clogb2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is visible on
// pop_data whenever the FIFO is not empty.
module sync_fifo_fwft
    import axis_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [clogb2(DEPTH):0]   level
);

    localparam int AW = clogb2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;

endmodule

// File: rtl/axis_uninvert_rx.sv
// Receives the bit-inverted loopback stream, restores the data, buffers it
// and forwards it while checking packet framing against C_PKT_LEN.
module axis_uninvert_rx
    import axis_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = C_DEFAULT_TDATA_WIDTH,
    parameter int C_M00_AXIS_TDATA_WIDTH = C_DEFAULT_TDATA_WIDTH,
    parameter int C_FIFO_DEPTH           = 16,
    parameter int C_PKT_LEN              = 64
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    input  logic                                  clear_err,
    output logic                                  len_err,
    output logic                                  ovr_err,
    output logic [15:0]                           pkt_count,
    output logic [clogb2(C_FIFO_DEPTH):0]         fifo_level
);

    localparam int STRB_W = C_S00_AXIS_TDATA_WIDTH / 8;
    localparam int FIFO_W = C_S00_AXIS_TDATA_WIDTH + STRB_W + 1;
    localparam int CNT_W  = clogb2(C_PKT_LEN) + 1;

    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] push_word;
    logic [FIFO_W-1:0] head_word;
    logic              s_accept;
    logic              m_pop;

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_inc;
    logic              set_len, set_ovr;

    assign s00_axis_tready = s00_axis_aresetn & ~fifo_full;
    assign s_accept        = s00_axis_tvalid & s00_axis_tready;
    assign push_word       = {~s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast};

    sync_fifo_fwft #(
        .WIDTH (FIFO_W),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (s00_axis_aclk),
        .resetn    (s00_axis_aresetn),
        .push      (s_accept),
        .push_data (push_word),
        .pop       (m_pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Head is masked while empty so the bus reads zero after reset.
    assign m00_axis_tvalid = ~fifo_empty;
    assign {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast} = fifo_empty ? '0 : head_word;
    assign m_pop = m00_axis_tvalid & m00_axis_tready;

    assign beat_cnt_inc = beat_cnt_q + 1'b1;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q    <= RX_IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Framing check only observes accepted beats; data always flows untouched.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        set_len    = 1'b0;
        set_ovr    = 1'b0;
        if (s_accept) begin
            case (state_q)
                RX_IDLE: begin
                    if (s00_axis_tlast) begin
                        set_len    = (C_PKT_LEN != 1);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = CNT_W'(1);
                        if (C_PKT_LEN == 1) begin
                            set_ovr = 1'b1;
                            state_d = RX_OVER;
                        end else begin
                            state_d = RX_PKT;
                        end
                    end
                end
                RX_PKT: begin
                    if (s00_axis_tlast) begin
                        set_len    = (beat_cnt_inc != CNT_W'(C_PKT_LEN));
                        beat_cnt_d = '0;
                        state_d    = RX_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_inc;
                        if (beat_cnt_inc == CNT_W'(C_PKT_LEN)) begin
                            set_ovr = 1'b1;
                            state_d = RX_OVER;
                        end
                    end
                end
                RX_OVER: begin
                    if (s00_axis_tlast) begin
                        set_len    = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = RX_IDLE;
                    end
                end
                default: begin
                    state_d    = RX_IDLE;
                    beat_cnt_d = '0;
                end
            endcase
        end
    end

    // A new error in the same cycle as clear_err wins over the clear.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            len_err   <= 1'b0;
            ovr_err   <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (set_len) begin
                len_err <= 1'b1;
            end else if (clear_err) begin
                len_err <= 1'b0;
            end
            if (set_ovr) begin
                ovr_err <= 1'b1;
            end else if (clear_err) begin
                ovr_err <= 1'b0;
            end
            if (m_pop && m00_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

endmodule
